mcpu_ctrl: RTL

Multi-cycle control sequencer for the MIPS-subset datapath. It replaces single-cycle combinational control. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the existing datapath control lines (RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Link, Shamt, AddrSrc, EXTOp, opcode) plus PC/IR write enables. It stalls on a data-memory ready handshake and counts retired instructions.

---
 rtl/mcpu_pkg.sv | 63 ++++++
 rtl/mcpu_decode.sv | 91 +++++++++
 rtl/mcpu_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control sequencer:
// FSM states, MIPS opcode/funct fields, ALU ops and datapath mux selects.
package mcpu_pkg;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_SLT = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6;

   localparam logic [1:0] ADDR_PC4 = 2'b00;
   localparam logic [1:0] ADDR_BR  = 2'b01;
   localparam logic [1:0] ADDR_JMP = 2'b10;
   localparam logic [1:0] ADDR_RS  = 2'b11;

   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_LUI  = 2'b10;

   typedef enum logic [2:0] {
      C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JR, C_JAL
   } iclass_e;

   typedef struct packed {
      logic       legal;
      iclass_e    iclass;
      logic       rtype;
      logic       alu_src;
      logic [1:0] ext_op;
      logic       shamt;
      logic [3:0] alu_op;
   } dec_t;

endpackage

// File: rtl/mcpu_decode.sv
// Combinational instruction decoder: classifies the IR word and derives the
// ALU controls used while the instruction is in flight.
module mcpu_decode
   import mcpu_pkg::*;
(
   input  logic [31:0] instr,
   output dec_t        dec
);

   logic [5:0] op;
   logic [5:0] fn;
   logic       unused_fields;

   assign op = instr[31:26];
   assign fn = instr[5:0];
   assign unused_fields = ^instr[25:6];

   always_comb begin
      dec.legal   = 1'b1;
      dec.iclass  = C_ALU;
      dec.rtype   = 1'b0;
      dec.alu_src = 1'b0;
      dec.ext_op  = EXT_ZERO;
      dec.shamt   = 1'b0;
      dec.alu_op  = ALU_ADD;
      case (op)
         OP_RTYPE: begin
            dec.rtype = 1'b1;
            case (fn)
               FN_ADDU: dec.alu_op = ALU_ADD;
               FN_SUBU: dec.alu_op = ALU_SUB;
               FN_AND:  dec.alu_op = ALU_AND;
               FN_OR:   dec.alu_op = ALU_OR;
               FN_SLT:  dec.alu_op = ALU_SLT;
               FN_SLL: begin
                  dec.alu_op = ALU_SLL;
                  dec.shamt  = 1'b1;
               end
               FN_SRL: begin
                  dec.alu_op = ALU_SRL;
                  dec.shamt  = 1'b1;
               end
               FN_JR:   dec.iclass = C_JR;
               default: dec.legal = 1'b0;
            endcase
         end
         OP_ADDIU: begin
            dec.alu_src = 1'b1;
            dec.ext_op  = EXT_SIGN;
         end
         OP_ANDI: begin
            dec.alu_src = 1'b1;
            dec.alu_op  = ALU_AND;
         end
         OP_ORI: begin
            dec.alu_src = 1'b1;
            dec.alu_op  = ALU_OR;
         end
         // lui is built as rs | (imm << 16)
         OP_LUI: begin
            dec.alu_src = 1'b1;
            dec.ext_op  = EXT_LUI;
            dec.alu_op  = ALU_OR;
         end
         OP_LW: begin
            dec.iclass  = C_LW;
            dec.alu_src = 1'b1;
            dec.ext_op  = EXT_SIGN;
         end
         OP_SW: begin
            dec.iclass  = C_SW;
            dec.alu_src = 1'b1;
            dec.ext_op  = EXT_SIGN;
         end
         OP_BEQ: begin
            dec.iclass = C_BEQ;
            dec.ext_op = EXT_SIGN;
            dec.alu_op = ALU_SUB;
         end
         OP_BNE: begin
            dec.iclass = C_BNE;
            dec.ext_op = EXT_SIGN;
            dec.alu_op = ALU_SUB;
         end
         OP_J:    dec.iclass = C_J;
         OP_JAL:  dec.iclass = C_JAL;
         default: dec.legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle control sequencer for the MIPS-subset datapath, with
// data-memory ready stall and a retired-instruction counter.
//
// state    | meaning
// ---------+-------------------------------------------------------
// S_FETCH  | load IR, PC <= PC+4
// S_DECODE | classify IR; illegal -> pulse illegal, back to FETCH
// S_EXEC   | ALU operation; branches/jumps resolve PC here
// S_MEM    | lw/sw strobe held until mem_ready
// S_WB     | register file write-back
module mcpu_ctrl
   import mcpu_pkg::*;
#(
   parameter int          CNT_W    = 32,
   parameter int unsigned LINK_REG = 31
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             RegDst,
   output logic             MemRead,
   output logic             MemtoReg,
   output logic             MemWrite,
   output logic             ALUSrc,
   output logic             RegWrite,
   output logic             Link,
   output logic             Shamt,
   output logic [1:0]       AddrSrc,
   output logic [1:0]       EXTOp,
   output logic [3:0]       opcode,
   output logic [4:0]       link_rd,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire;
   dec_t             dec;

   mcpu_decode u_decode (
      .instr (instr),
      .dec   (dec)
   );

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: state_d = dec.legal ? S_EXEC : S_FETCH;
         S_EXEC: begin
            case (dec.iclass)
               C_BEQ, C_BNE, C_J, C_JR: begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
               C_LW, C_SW: state_d = S_MEM;
               default:    state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               if (dec.iclass == C_SW) begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemRead  = 1'b0;
      MemtoReg = 1'b0;
      MemWrite = 1'b0;
      ALUSrc   = 1'b0;
      RegWrite = 1'b0;
      Link     = 1'b0;
      Shamt    = 1'b0;
      AddrSrc  = ADDR_PC4;
      EXTOp    = EXT_ZERO;
      opcode   = ALU_ADD;
      illegal  = 1'b0;
      // ALU controls stay up through MEM/WB so the ALU result feeding the
      // memory address or write-back data is stable without an ALUOut latch.
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
         ALUSrc = dec.alu_src;
         EXTOp  = dec.ext_op;
         Shamt  = dec.shamt;
         opcode = dec.alu_op;
      end
      case (state_q)
         S_FETCH: begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
         end
         S_DECODE: illegal = ~dec.legal;
         S_EXEC: begin
            case (dec.iclass)
               C_BEQ: begin
                  PCWrite = zero;
                  AddrSrc = ADDR_BR;
               end
               C_BNE: begin
                  PCWrite = ~zero;
                  AddrSrc = ADDR_BR;
               end
               C_J, C_JAL: begin
                  PCWrite = 1'b1;
                  AddrSrc = ADDR_JMP;
               end
               C_JR: begin
                  PCWrite = 1'b1;
                  AddrSrc = ADDR_RS;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            MemRead  = (dec.iclass == C_LW);
            MemWrite = (dec.iclass == C_SW);
         end
         S_WB: begin
            RegWrite = 1'b1;
            RegDst   = dec.rtype;
            MemtoReg = (dec.iclass == C_LW);
            Link     = (dec.iclass == C_JAL);
         end
         default: ;
      endcase
   end

   assign link_rd = 5'(LINK_REG);
   assign retired = retired_q;

endmodule
